ysyx_25070198_arbiter: RTL and testbench
========================================

YSYX_25070198_ARBITER -- requirements
Module: ysyx_25070198_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: BUSY cycles without bus_respValid before an error response.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ifu_reqValid  input  1  IFU read request.
REQ-005 SHALL have port ifu_addr  input  32  IFU fetch address.
REQ-006 SHALL have port ifu_respValid  output  1  IFU response strobe.
REQ-007 SHALL have port ifu_rdata  output  32  IFU read data.
REQ-008 SHALL have port ifu_respErr  output  1  IFU timeout error.
REQ-009 SHALL have port lsu_reqValid  input  1  LSU request.
REQ-010 SHALL have port lsu_addr / lsu_wdata  input  32 each  LSU address / write data.
REQ-011 SHALL have port lsu_wen  input  1  LSU write enable.
REQ-012 SHALL have port lsu_wmask  input  4  LSU byte mask.
REQ-013 SHALL have port lsu_respValid / lsu_respErr  output  1 each  LSU response strobe / timeout error.
REQ-014 SHALL have port lsu_rdata  output  32  LSU read data.
REQ-015 SHALL have port bus_reqValid / bus_wen  output  1 each  shared SimpleBus request / write enable.
REQ-016 SHALL have port bus_addr / bus_wdata  output  32 each  bus address / write data.
REQ-017 SHALL have port bus_wmask  output  4  bus byte mask.
REQ-018 SHALL have port bus_respValid  input  1 and bus_rdata  input  32  slave response.

Function
REQ-019 SHALL implement states IDLE, BUSY_IFU, BUSY_LSU.
REQ-020 In IDLE with exactly one reqValid high, SHALL latch that master's addr/wen/wdata/wmask (IFU: wen=0, wdata=0, wmask=0) and move to its BUSY state next cycle.
REQ-021 On simultaneous requests in IDLE SHALL grant the master not recorded in last_grant (round-robin).
REQ-022 SHALL drive bus_reqValid=1 and bus_* from latched registers throughout BUSY_x; in IDLE, bus_reqValid=0 and bus_addr/wen/wdata/wmask=0.
REQ-023 Latched request SHALL NOT change during BUSY even if the master changes or drops its inputs.
REQ-024 In BUSY_x with bus_respValid=1, SHALL assert x_respValid=1, x_rdata=bus_rdata, x_respErr=0 in that same cycle (combinational), then go IDLE and set last_grant=x.
REQ-025 Non-granted master SHALL see respValid=0, rdata=0, respErr=0 at all times.
REQ-026 Timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without bus_respValid.
REQ-027 When the counter equals TIMEOUT_CYCLES-1 and bus_respValid=0, SHALL assert x_respValid=1, x_respErr=1, x_rdata=0 that cycle, go IDLE next cycle and set last_grant=x.
REQ-028 bus_respValid in the timeout cycle SHALL take precedence: normal response, respErr=0.
REQ-029 bus_respValid in IDLE SHALL be ignored.
REQ-030 Any reqValid high in IDLE (including the cycle after a response) SHALL be a new request; minimum IDLE dwell between transactions is one cycle.
REQ-031 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1) bits with no wrap in BUSY.

Reset
REQ-032 On rst SHALL enter IDLE, clear latched request and counter, set last_grant=IFU; all outputs 0 in the cycle after rst is sampled.
REQ-033 rst asserted mid-transaction SHALL abandon it with no response to either master; the slave's late bus_respValid is ignored per REQ-029.

Structure
REQ-034 Shared package ysyx_25070198_pkg SHALL hold the arbiter state enum and the master-id enum (MST_IFU, MST_LSU).
REQ-035 Timeout counter SHALL be sub-module ysyx_25070198_timeout_cnt (inputs clr, en; output expired).

Verification
REQ-036 IFU only, addr 0x8000_0000, slave responds 3 cycles later with 0x0000_0413 -> bus_addr 0x8000_0000, wen=0; ifu_respValid one cycle with rdata 0x0000_0413; lsu_respValid stays 0.
REQ-037 LSU write addr 0x8000_1000, wdata 0xDEAD_BEEF, wmask 0xF, LSU drops wen next cycle -> bus_wen stays 1, bus_wdata 0xDEAD_BEEF until bus_respValid.
REQ-038 Both request every IDLE cycle after reset -> grants LSU, IFU, LSU, IFU in order.
REQ-039 TIMEOUT_CYCLES=4, slave silent -> ifu_respValid=1, ifu_respErr=1, rdata=0 in 4th BUSY cycle; IDLE next cycle.
REQ-040 rst pulsed in 2nd BUSY cycle, slave responds 2 cycles later -> no master respValid; bus_reqValid=0 after reset.

Source files
------------

// File: rtl/ysyx_25070198_pkg.sv
// Shared types for the IFU/LSU SimpleBus arbiter.
package ysyx_25070198_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusyIfu,
    StBusyLsu
  } arb_state_e;

  typedef enum logic {
    MST_IFU,
    MST_LSU
  } mst_e;

  // Round-robin pick when both masters request in the same idle cycle.
  function automatic mst_e rr_pick(input mst_e last_grant);
    return (last_grant == MST_IFU) ? MST_LSU : MST_IFU;
  endfunction

endpackage

// File: rtl/ysyx_25070198_timeout_cnt.sv
// Busy-cycle counter; expired flags the last cycle a transaction may wait for the slave.
module ysyx_25070198_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LastCnt);

  // Holds at the terminal value instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ysyx_25070198_arbiter.sv
// Two-master (IFU, LSU) round-robin arbiter onto one SimpleBus slave, with
// a per-transaction response timeout.
module ysyx_25070198_arbiter
  import ysyx_25070198_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_respErr,

  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic        lsu_wen,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic        lsu_respErr,
  output logic [31:0] lsu_rdata,

  output logic        bus_reqValid,
  output logic        bus_wen,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_respValid,
  input  logic [31:0] bus_rdata
);

  arb_state_e  state_q, state_d;
  mst_e        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [3:0]  wmask_q, wmask_d;

  logic        busy;
  logic        expired;
  mst_e        grant;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  assign busy = (state_q != StIdle);

  ysyx_25070198_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (!busy),
    .en     (busy && !bus_respValid),
    .expired(expired)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wen_d        = wen_q;
    wmask_d      = wmask_q;
    grant        = MST_IFU;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    resp_rdata   = '0;
    bus_reqValid = 1'b0;
    bus_wen      = 1'b0;
    bus_addr     = '0;
    bus_wdata    = '0;
    bus_wmask    = '0;

    unique case (state_q)
      StIdle: begin
        if (ifu_reqValid || lsu_reqValid) begin
          if (ifu_reqValid && lsu_reqValid) begin
            grant = rr_pick(last_grant_q);
          end else begin
            grant = ifu_reqValid ? MST_IFU : MST_LSU;
          end
          if (grant == MST_IFU) begin
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
            state_d = StBusyIfu;
          end else begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
            state_d = StBusyLsu;
          end
        end
      end
      StBusyIfu, StBusyLsu: begin
        bus_reqValid = 1'b1;
        bus_wen      = wen_q;
        bus_addr     = addr_q;
        bus_wdata    = wdata_q;
        bus_wmask    = wmask_q;
        // A real response wins over a timeout landing in the same cycle.
        if (bus_respValid || expired) begin
          resp_valid   = 1'b1;
          resp_err     = !bus_respValid;
          resp_rdata   = bus_respValid ? bus_rdata : '0;
          state_d      = StIdle;
          last_grant_d = (state_q == StBusyIfu) ? MST_IFU : MST_LSU;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ifu_respValid = resp_valid && (state_q == StBusyIfu);
    ifu_respErr   = resp_err && (state_q == StBusyIfu);
    ifu_rdata     = (state_q == StBusyIfu) ? resp_rdata : '0;
    lsu_respValid = resp_valid && (state_q == StBusyLsu);
    lsu_respErr   = resp_err && (state_q == StBusyLsu);
    lsu_rdata     = (state_q == StBusyLsu) ? resp_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= MST_IFU;
      addr_q       <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wen_q        <= wen_d;
      wmask_q      <= wmask_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25070198_arbiter.sv
// Directed self-checking bench for the IFU/LSU SimpleBus arbiter.
module tb_ysyx_25070198_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        ifu_respErr;
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_wen;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic        lsu_respErr;
  logic [31:0] lsu_rdata;
  logic        bus_reqValid;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_respValid;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_25070198_arbiter #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_reqValid (ifu_reqValid),
    .ifu_addr     (ifu_addr),
    .ifu_respValid(ifu_respValid),
    .ifu_rdata    (ifu_rdata),
    .ifu_respErr  (ifu_respErr),
    .lsu_reqValid (lsu_reqValid),
    .lsu_addr     (lsu_addr),
    .lsu_wdata    (lsu_wdata),
    .lsu_wen      (lsu_wen),
    .lsu_wmask    (lsu_wmask),
    .lsu_respValid(lsu_respValid),
    .lsu_respErr  (lsu_respErr),
    .lsu_rdata    (lsu_rdata),
    .bus_reqValid (bus_reqValid),
    .bus_wen      (bus_wen),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wmask    (bus_wmask),
    .bus_respValid(bus_respValid),
    .bus_rdata    (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rr_addr [4];

  initial begin
    rst           = 1'b1;
    ifu_reqValid  = 1'b0;
    ifu_addr      = '0;
    lsu_reqValid  = 1'b0;
    lsu_addr      = '0;
    lsu_wdata     = '0;
    lsu_wen       = 1'b0;
    lsu_wmask     = '0;
    bus_respValid = 1'b0;
    bus_rdata     = '0;
    rr_addr[0] = 32'h0000_0200;
    rr_addr[1] = 32'h0000_0100;
    rr_addr[2] = 32'h0000_0200;
    rr_addr[3] = 32'h0000_0100;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check_eq("rst_bus_req", bus_reqValid, 0);
    check_eq("rst_bus_addr", bus_addr, 0);
    check_eq("rst_bus_wen", bus_wen, 0);
    check_eq("rst_bus_wdata", bus_wdata, 0);
    check_eq("rst_bus_wmask", bus_wmask, 0);
    check_eq("rst_ifu_resp", ifu_respValid, 0);
    check_eq("rst_lsu_resp", lsu_respValid, 0);

    // IFU-only fetch, slave answers in the third busy cycle
    tick();
    rst          = 1'b0;
    ifu_reqValid = 1'b1;
    ifu_addr     = 32'h8000_0000;
    @(negedge clk);
    check_eq("ifu_idle_bus_req", bus_reqValid, 0);
    tick();
    ifu_reqValid = 1'b0;
    ifu_addr     = 32'h1234_5678;
    @(negedge clk);
    check_eq("ifu_bus_req", bus_reqValid, 1);
    check_eq("ifu_bus_addr", bus_addr, 32'h8000_0000);
    check_eq("ifu_bus_wen", bus_wen, 0);
    check_eq("ifu_bus_wmask", bus_wmask, 0);
    check_eq("ifu_no_resp_b1", ifu_respValid, 0);
    tick();
    tick();
    bus_respValid = 1'b1;
    bus_rdata     = 32'h0000_0413;
    @(negedge clk);
    check_eq("ifu_resp_valid", ifu_respValid, 1);
    check_eq("ifu_resp_rdata", ifu_rdata, 32'h0000_0413);
    check_eq("ifu_resp_err", ifu_respErr, 0);
    check_eq("ifu_lsu_quiet", lsu_respValid, 0);
    check_eq("ifu_lsu_rdata0", lsu_rdata, 0);
    tick();
    bus_respValid = 1'b0;
    @(negedge clk);
    check_eq("ifu_resp_one_cycle", ifu_respValid, 0);
    check_eq("ifu_back_idle", bus_reqValid, 0);

    // LSU write; master changes its inputs while busy
    lsu_reqValid = 1'b1;
    lsu_addr     = 32'h8000_1000;
    lsu_wdata    = 32'hDEAD_BEEF;
    lsu_wmask    = 4'hF;
    lsu_wen      = 1'b1;
    tick();
    lsu_reqValid = 1'b0;
    lsu_wen      = 1'b0;
    lsu_wdata    = '0;
    lsu_addr     = '0;
    lsu_wmask    = '0;
    @(negedge clk);
    check_eq("lsu_bus_wen", bus_wen, 1);
    check_eq("lsu_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    check_eq("lsu_bus_addr", bus_addr, 32'h8000_1000);
    check_eq("lsu_bus_wmask", bus_wmask, 32'hF);
    tick();
    @(negedge clk);
    check_eq("lsu_bus_wen_hold", bus_wen, 1);
    check_eq("lsu_bus_wdata_hold", bus_wdata, 32'hDEAD_BEEF);
    tick();
    bus_respValid = 1'b1;
    bus_rdata     = 32'h0000_55AA;
    @(negedge clk);
    check_eq("lsu_resp_valid", lsu_respValid, 1);
    check_eq("lsu_resp_rdata", lsu_rdata, 32'h0000_55AA);
    check_eq("lsu_resp_err", lsu_respErr, 0);
    check_eq("lsu_ifu_quiet", ifu_respValid, 0);
    check_eq("lsu_ifu_rdata0", ifu_rdata, 0);
    tick();
    bus_respValid = 1'b0;

    // Both masters request continuously: round-robin from reset
    rst = 1'b1;
    tick();
    rst          = 1'b0;
    ifu_reqValid = 1'b1;
    ifu_addr     = 32'h0000_0100;
    lsu_reqValid = 1'b1;
    lsu_addr     = 32'h0000_0200;
    lsu_wen      = 1'b1;
    lsu_wdata    = 32'h0000_0077;
    lsu_wmask    = 4'h3;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus_respValid = 1'b1;
      bus_rdata     = 32'(i + 1);
      @(negedge clk);
      check_eq($sformatf("rr_addr_%0d", i), bus_addr, rr_addr[i]);
      check_eq($sformatf("rr_lsu_resp_%0d", i), lsu_respValid, (i % 2 == 0) ? 1 : 0);
      check_eq($sformatf("rr_ifu_resp_%0d", i), ifu_respValid, (i % 2 == 1) ? 1 : 0);
      tick();
      bus_respValid = 1'b0;
      @(negedge clk);
      check_eq($sformatf("rr_idle_dwell_%0d", i), bus_reqValid, 0);
    end
    ifu_reqValid = 1'b0;
    lsu_reqValid = 1'b0;
    lsu_wen      = 1'b0;

    // Timeout with a silent slave
    tick();
    ifu_reqValid = 1'b1;
    ifu_addr     = 32'h0000_0300;
    bus_rdata    = 32'hFFFF_FFFF;
    tick();
    ifu_reqValid = 1'b0;
    @(negedge clk);
    check_eq("to_b1_resp", ifu_respValid, 0);
    tick();
    tick();
    @(negedge clk);
    check_eq("to_b3_resp", ifu_respValid, 0);
    tick();
    @(negedge clk);
    check_eq("to_resp_valid", ifu_respValid, 1);
    check_eq("to_resp_err", ifu_respErr, 1);
    check_eq("to_resp_rdata", ifu_rdata, 0);
    check_eq("to_lsu_quiet", lsu_respValid, 0);
    tick();
    @(negedge clk);
    check_eq("to_idle_bus_req", bus_reqValid, 0);
    check_eq("to_idle_resp", ifu_respValid, 0);

    // Response in the timeout cycle wins
    ifu_reqValid = 1'b1;
    tick();
    ifu_reqValid = 1'b0;
    tick();
    tick();
    tick();
    bus_respValid = 1'b1;
    bus_rdata     = 32'h0000_CAFE;
    @(negedge clk);
    check_eq("race_resp_valid", ifu_respValid, 1);
    check_eq("race_resp_err", ifu_respErr, 0);
    check_eq("race_resp_rdata", ifu_rdata, 32'h0000_CAFE);
    tick();
    bus_respValid = 1'b0;

    // Reset mid-transaction, late slave response ignored
    ifu_reqValid = 1'b1;
    tick();
    ifu_reqValid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_bus_req", bus_reqValid, 0);
    check_eq("mid_rst_ifu_resp", ifu_respValid, 0);
    tick();
    bus_respValid = 1'b1;
    bus_rdata     = 32'h0000_0099;
    @(negedge clk);
    check_eq("late_ifu_resp", ifu_respValid, 0);
    check_eq("late_lsu_resp", lsu_respValid, 0);
    check_eq("late_ifu_rdata", ifu_rdata, 0);
    check_eq("late_bus_req", bus_reqValid, 0);
    tick();
    @(negedge clk);
    check_eq("late2_ifu_resp", ifu_respValid, 0);
    bus_respValid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
